adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : SPI scan controller for a two-channel 12-bit ADC. Frames
//               alternate CH0 (accelerator) and CH1 (light sensor). Each
//               frame drives chip select low for 18 SCK periods plus a
//               leading half period. It shifts out the 4-bit command
//               (start, SGL, channel, MSBF) and captures the 12-bit result.
//               It then publishes the result with a one-cycle valid pulse.
// Options     : define ADC_AVG_EN to publish CH0 as the average of the last
//               four CH0 samples instead of the latest sample alone.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
  parameter int unsigned SCK_DIV = 25,  // clk cycles per SCK half-period
  parameter int unsigned CS_IDLE = 50   // minimum clk cycles with CS high
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        spi_dout_i,
  output logic        spi_sck_o,
  output logic        spi_ad_o,
  output logic        spi_din_o,
  output logic [7:0]  adc_accel_o,
  output logic [11:0] adc_cds_o,
  output logic        accel_vld_o,
  output logic        cds_vld_o,
  output logic        busy_o
);

  localparam int unsigned DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned IDLE_W = (CS_IDLE > 0) ? $clog2(CS_IDLE + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(CS_IDLE);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  // A frame is 37 SCK half-phases (0..36). Odd phases are SCK high, so
  // rising edge k starts phase 2k-1. Phase 36 is the trailing low half
  // after rising edge 18, which keeps CS low for a full 18 SCK periods
  // measured from the leading half period.
  localparam logic [5:0] HALF_LAST   = 6'd36;
  localparam logic [5:0] HALF_SAMPLE = 6'd12;  // phase before rising edge 7

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q,  idle_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [5:0]          half_q,  half_d;
  logic                ch_q,    ch_d;
  logic [11:0]         shift_q, shift_d;
  logic                sck_q,   sck_d;
  logic                ad_q,    ad_d;
  logic                din_q,   din_d;
  logic [7:0]          accel_q, accel_d;
  logic [11:0]         cds_q,   cds_d;
  logic                accel_vld_q, accel_vld_d;
  logic                cds_vld_q,   cds_vld_d;

`ifdef ADC_AVG_EN
  // hist_q[3] is the oldest CH0 sample, hist_q[0] the newest.
  logic [3:0][11:0]    hist_q, hist_d;
  logic [13:0]         sum_q,  sum_d;
`endif

  // Next-state, counters, result capture and SPI pin values.
  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    div_d       = div_q;
    half_d      = half_q;
    ch_d        = ch_q;
    shift_d     = shift_q;
    sck_d       = 1'b0;
    ad_d        = 1'b1;
    din_d       = 1'b0;
    accel_d     = accel_q;
    cds_d       = cds_q;
    accel_vld_d = 1'b0;
    cds_vld_d   = 1'b0;
`ifdef ADC_AVG_EN
    hist_d      = hist_q;
    sum_d       = sum_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        half_d = '0;
        // Saturate so that a long EN-low period still allows a prompt start.
        if (idle_q != IDLE_LAST) begin
          idle_d = idle_q + IDLE_ONE;
        end
        if (en_i && (idle_q == IDLE_LAST)) begin
          state_d = ST_XFER;
          idle_d  = '0;
        end
      end

      ST_XFER: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = ST_DONE;
            if (!ch_q) begin
`ifdef ADC_AVG_EN
              sum_d   = sum_q - {2'b00, hist_q[3]} + {2'b00, shift_q};
              hist_d  = {hist_q[2:0], shift_q};
              accel_d = sum_d[13:6];
`else
              accel_d = shift_q[11:4];
`endif
              accel_vld_d = 1'b1;
            end else begin
              cds_d     = shift_q;
              cds_vld_d = 1'b1;
            end
          end else begin
            half_d = half_q + 6'd1;
            // Leaving an even phase is a rising SCK edge; edges 7..18
            // carry B11..B0, edges up to 6 (incl. the null bit) are ignored.
            if (!half_q[0] && (half_q >= HALF_SAMPLE)) begin
              shift_d = {shift_q[10:0], spi_dout_i};
            end
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        idle_d  = '0;
        div_d   = '0;
        half_d  = '0;
        ch_d    = ~ch_q;
      end

      default: begin
        state_d = ST_IDLE;
        idle_d  = '0;
        div_d   = '0;
        half_d  = '0;
      end
    endcase

    // Pin values follow the upcoming phase so that they leave registers.
    // DIN only moves on low phases, so it is stable around each rising edge.
    if (state_d == ST_XFER) begin
      ad_d  = 1'b0;
      sck_d = half_d[0];
      if (half_d[0]) begin
        din_d = din_q;
      end else begin
        case (half_d[5:1])
          5'd0:    din_d = 1'b1;   // start
          5'd1:    din_d = 1'b1;   // single-ended
          5'd2:    din_d = ch_q;   // channel select
          5'd3:    din_d = 1'b1;   // MSB first
          default: din_d = 1'b0;
        endcase
      end
    end
  end

  // State, counters and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idle_q      <= '0;
      div_q       <= '0;
      half_q      <= '0;
      ch_q        <= 1'b0;
      shift_q     <= '0;
      sck_q       <= 1'b0;
      ad_q        <= 1'b1;
      din_q       <= 1'b0;
      accel_q     <= '0;
      cds_q       <= '0;
      accel_vld_q <= 1'b0;
      cds_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      div_q       <= div_d;
      half_q      <= half_d;
      ch_q        <= ch_d;
      shift_q     <= shift_d;
      sck_q       <= sck_d;
      ad_q        <= ad_d;
      din_q       <= din_d;
      accel_q     <= accel_d;
      cds_q       <= cds_d;
      accel_vld_q <= accel_vld_d;
      cds_vld_q   <= cds_vld_d;
    end
  end

`ifdef ADC_AVG_EN
  // CH0 averaging history and its running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      sum_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end
`endif

  assign spi_sck_o   = sck_q;
  assign spi_ad_o    = ad_q;
  assign spi_din_o   = din_q;
  assign adc_accel_o = accel_q;
  assign adc_cds_o   = cds_q;
  assign accel_vld_o = accel_vld_q;
  assign cds_vld_o   = cds_vld_q;
  assign busy_o      = ~ad_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_ctrl
// Description : Self-checking bench for adc_scan_ctrl with an ADC model and
//               a frame-level reference model (channel alternation, command
//               bits, result scaling or 4-sample averaging).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

  localparam int SCK_DIV   = 3;
  localparam int CS_IDLE   = 8;
  localparam int FRAME_LOW = 37 * SCK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        dout = 1'b0;
  logic        sck, ad, din, accel_vld, cds_vld, busy;
  logic [7:0]  accel;
  logic [11:0] cds;

  int tests_run    = 0;
  int tests_failed = 0;

  adc_scan_ctrl #(.SCK_DIV(SCK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .spi_dout_i  (dout),
    .spi_sck_o   (sck),
    .spi_ad_o    (ad),
    .spi_din_o   (din),
    .adc_accel_o (accel),
    .adc_cds_o   (cds),
    .accel_vld_o (accel_vld),
    .cds_vld_o   (cds_vld),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int  m_ch;
  int  q0[$];
  int  exp_accel, exp_cds;
  int  frame_val, frame_ch;
  bit  in_frame;
  int  rises, low_cnt, high_cnt, din_cmd, nxt, s;
  logic prev_ad, prev_sck, prev_din;
  bit  viol_din, viol_sck, viol_busy, viol_vld, pend;
  int  frames_done = 0;
  int  val0, val1;
  bit  rnd_vals;

  // ADC model plus frame observer, sampling between rising clock edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ch = 0; q0.delete(); exp_accel = 0; exp_cds = 0;
      in_frame = 0; prev_ad = 1'b1; prev_sck = 1'b0; prev_din = 1'b0;
      high_cnt = 0; low_cnt = 0; rises = 0; pend = 0; dout = 1'b0;
      viol_din = 0; viol_sck = 0; viol_busy = 0; viol_vld = 0;
    end else begin
      if (busy !== ~ad) viol_busy = 1;
      if (ad && sck) viol_sck = 1;
      if (pend) begin
        check("vld_one_cycle", {30'd0, accel_vld, cds_vld}, 0);
        pend = 0;
      end else if (!(!prev_ad && ad) && (accel_vld || cds_vld)) begin
        viol_vld = 1;
      end

      if (prev_ad && !ad) begin
        check("cs_gap", high_cnt >= CS_IDLE, 1);
        in_frame = 1; low_cnt = 0; rises = 0; din_cmd = 0; viol_din = 0;
        frame_ch = m_ch;
        frame_val = rnd_vals ? int'($urandom_range(0, 4095)) : (m_ch != 0 ? val1 : val0);
        dout = 1'($urandom_range(0, 1));
      end

      if (in_frame && !prev_sck && sck) begin
        rises++;
        if (din !== prev_din) viol_din = 1;
        if (rises <= 4) din_cmd = (din_cmd << 1) | int'(din);
        else if (din !== 1'b0) viol_din = 1;
      end
      if (in_frame && prev_sck && sck && din !== prev_din) viol_din = 1;
      if (in_frame && prev_sck && !sck) begin
        nxt = rises + 1;
        if (nxt >= 7 && nxt <= 18) dout = 1'((frame_val >> (18 - nxt)) & 1);
        else dout = 1'($urandom_range(0, 1));
      end

      if (!prev_ad && ad && in_frame) begin
        in_frame = 0;
        check("cs_low_cycles", low_cnt, FRAME_LOW);
        check("sck_rises", rises, 18);
        check("din_cmd", din_cmd, frame_ch != 0 ? 4'b1111 : 4'b1101);
        check("din_rules", viol_din, 0);
        if (frame_ch == 0) begin
          q0.push_back(frame_val);
          if (q0.size() > 4) void'(q0.pop_front());
`ifdef ADC_AVG_EN
          s = 0;
          foreach (q0[i]) s += q0[i];
          exp_accel = s / 64;
`else
          exp_accel = frame_val / 16;
`endif
          check("accel_vld", accel_vld, 1);
          check("cds_vld_quiet", cds_vld, 0);
        end else begin
          exp_cds = frame_val;
          check("cds_vld", cds_vld, 1);
          check("accel_vld_quiet", accel_vld, 0);
        end
        check("adc_accel", accel, exp_accel);
        check("adc_cds", cds, exp_cds);
        check("busy_track", viol_busy, 0);
        check("sck_idle_low", viol_sck, 0);
        check("vld_spurious", viol_vld, 0);
        viol_busy = 0; viol_sck = 0; viol_vld = 0;
        pend = 1;
        m_ch ^= 1;
        frames_done++;
      end

      if (ad) begin
        if (!prev_ad) high_cnt = 0;
        high_cnt++;
      end else begin
        low_cnt++;
      end
      prev_ad = ad; prev_sck = sck; prev_din = din;
    end
  end

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int cyc = 0;
    while (frames_done < target && cyc < 600 * n) begin
      @(negedge clk); #1; cyc++;
    end
    check("frame_timeout", frames_done >= target, 1);
  endtask

  task automatic wait_rises(input int k);
    int cyc = 0;
    while (!(in_frame && rises >= k) && cyc < 2000) begin
      @(negedge clk); #1; cyc++;
    end
    check("rise_timeout", in_frame && rises >= k, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ad"}, ad, 1);
    check({tag, "_sck"}, sck, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_accel"}, accel, 0);
    check({tag, "_cds"}, cds, 0);
    check({tag, "_accel_vld"}, accel_vld, 0);
    check({tag, "_cds_vld"}, cds_vld, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    bit stayed;
    int avg_tab[4];
    rnd_vals = 0; val0 = 1000; val1 = 2000;
    repeat (3) @(negedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    en = 1'b1;

    // Directed first two frames: CH0 = 1000, CH1 = 2000
    wait_frames(1);
`ifndef ADC_AVG_EN
    check("accel_1000", accel, 62);
`endif
    wait_frames(1);
    check("cds_2000", cds, 2000);

    // Random sample values with random EN gaps
    rnd_vals = 1;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 150)) @(negedge clk);
        en = 1'b1;
      end
      wait_frames(1);
    end

    // EN drops at rising edge 10: frame completes, then CS stays high
    wait_rises(10);
    en = 1'b0;
    wait_frames(1);
    stayed = 1;
    repeat (4 * CS_IDLE + 20) begin
      @(negedge clk); #1;
      if (!ad) stayed = 0;
    end
    check("en_low_hold", stayed, 1);
    en = 1'b1;
    n = 0;
    while (ad && n < CS_IDLE + 5) begin
      @(negedge clk); #1; n++;
    end
    check("en_restart", !ad, 1);

    // Reset in the middle of a transfer
    wait_rises(5);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid_xfer");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Constant CH0 = 4000 for four CH0 frames after reset
    rnd_vals = 0; val0 = 4000; val1 = 123;
`ifdef ADC_AVG_EN
    avg_tab = '{62, 125, 187, 250};
`else
    avg_tab = '{250, 250, 250, 250};
`endif
    for (int i = 0; i < 4; i++) begin
      wait_frames(1);
      check("accel_4000", accel, avg_tab[i]);
      wait_frames(1);
      check("cds_123", cds, 123);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
